dcache_wb: RTL and testbench

Direct-mapped, write-back, write-allocate cache between the pipeline's 32-bit word interface and the slow 128-bit block memory. One instance serves data and one serves instructions (instruction side never writes). It hides memory latency on hits and stalls the pipeline via proc_stall on misses. Stall is raised in the same cycle as the request.

---
 rtl/dcache_wb_pkg.sv | 27 ++
 rtl/dcache_wb_line_array.sv | 55 +++++
 rtl/dcache_wb.sv | 115 +++++++++++
 tb/tb_dcache_wb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_wb_pkg.sv
// Shared types, sizing constants and address-slice helpers for the write-back data cache.
package dcache_wb_pkg;

  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W      = 30 - 2 - IDX_W;
  localparam int unsigned BLOCK_W    = 128;

  typedef enum logic [1:0] {
    StCompare   = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } state_e;

  function automatic logic [1:0] addr_off(input logic [29:0] addr);
    return addr[1:0];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [29:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [29:0] addr);
    return addr[29:IDX_W+2];
  endfunction

endpackage

// File: rtl/dcache_wb_line_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one masked write port.
module dcache_wb_line_array
  import dcache_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_o,
  output logic               rd_dirty_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [BLOCK_W-1:0] rd_data_o,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [3:0]         wr_mask_i,
  input  logic [BLOCK_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               wr_dirty_i
);

  logic               valid_q [NUM_BLOCKS];
  logic               dirty_q [NUM_BLOCKS];
  logic [TAG_W-1:0]   tag_q   [NUM_BLOCKS];
  logic [BLOCK_W-1:0] data_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0] line_d;

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Merge only the enabled words into the addressed line; a fill enables all four.
  always_comb begin
    line_d = data_q[wr_idx_i];
    for (int w = 0; w < 4; w++) begin
      if (wr_mask_i[w]) line_d[w*32 +: 32] = wr_data_i[w*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
      tag_q[wr_idx_i]   <= wr_tag_i;
      data_q[wr_idx_i]  <= line_d;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate cache: FSM, hit detection and word muxing.
module dcache_wb
  import dcache_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [29:0]        proc_addr,
  input  logic [31:0]        proc_wdata,
  output logic [31:0]        proc_rdata,
  output logic               proc_stall,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready
);

  state_e state_q, state_d;

  logic [1:0]         off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid, rd_dirty, hit, req;
  logic [TAG_W-1:0]   rd_tag;
  logic [BLOCK_W-1:0] rd_data;

  logic               wr_en, wr_dirty;
  logic [3:0]         wr_mask;
  logic [BLOCK_W-1:0] wr_data;

  assign off = addr_off(proc_addr);
  assign idx = addr_idx(proc_addr);
  assign tag = addr_tag(proc_addr);
  assign req = proc_read | proc_write;
  assign hit = rd_valid & (rd_tag == tag);

  assign proc_rdata = rd_data[{off, 5'd0} +: 32];

  dcache_wb_line_array u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (idx),
    .wr_mask_i  (wr_mask),
    .wr_data_i  (wr_data),
    .wr_tag_i   (tag),
    .wr_dirty_i (wr_dirty)
  );

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    wr_mask    = 4'b0000;
    wr_data    = '0;
    wr_dirty   = 1'b0;

    unique case (state_q)
      StCompare: begin
        if (req) begin
          if (hit) begin
            // Write wins when both strobes are high; a write-allocate merge lands here too.
            if (proc_write) begin
              wr_en    = 1'b1;
              wr_mask  = 4'b0001 << off;
              wr_data  = {4{proc_wdata}};
              wr_dirty = 1'b1;
            end
          end else begin
            proc_stall = 1'b1;
            state_d    = (rd_valid && rd_dirty) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {rd_tag, idx};
        mem_wdata  = rd_data;
        if (mem_ready) state_d = StAllocate;
      end
      StAllocate: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) begin
          wr_en    = 1'b1;
          wr_mask  = 4'b1111;
          wr_data  = mem_rdata;
          wr_dirty = 1'b0;
          state_d  = StCompare;
        end
      end
      default: state_d = StCompare;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StCompare;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb: cold miss, hits, dirty/clean eviction, reset mid-miss.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dcache_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_return(input logic [127:0] blk);
    mem_rdata = blk;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    #2;
    check_eq("rst_stall", proc_stall, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    #10 rst_n = 1'b1;
    tick();

    // Stray mem_ready while idle must be ignored.
    mem_return(128'hFFFF);
    check_eq("idle_ready_no_read", mem_read, 0);
    check_eq("idle_ready_stall", proc_stall, 0);

    // Cold read miss at 0x10 (idx 4, tag 0).
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #1;
    check_eq("cold_stall_same_cycle", proc_stall, 1);
    tick();
    check_eq("cold_mem_read", mem_read, 1);
    check_eq("cold_mem_write", mem_write, 0);
    check_eq("cold_mem_addr", mem_addr, 28'h4);
    tick(); tick(); tick();
    check_eq("cold_still_waiting", proc_stall, 1);
    mem_return(128'h33333333_22222222_11111111_00000000);
    check_eq("cold_mem_read_drop", mem_read, 0);
    check_eq("cold_stall_clear", proc_stall, 0);
    check_eq("cold_rdata", proc_rdata, 32'h00000000);

    // Zero-latency read hit.
    proc_addr = 30'h11;
    #1;
    check_eq("hit_stall", proc_stall, 0);
    check_eq("hit_rdata", proc_rdata, 32'h11111111);
    check_eq("hit_mem_read", mem_read, 0);

    // Write hit, then read back.
    tick();
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h12;
    proc_wdata = 32'hDEADBEEF;
    #1;
    check_eq("wr_hit_stall", proc_stall, 0);
    tick();
    proc_write = 1'b0;
    proc_read  = 1'b1;
    #1;
    check_eq("wr_hit_readback", proc_rdata, 32'hDEADBEEF);

    // Read and write together: the write must take effect.
    tick();
    proc_write = 1'b1;
    proc_addr  = 30'h13;
    proc_wdata = 32'hCAFEF00D;
    tick();
    proc_write = 1'b0;
    #1;
    check_eq("wr_precedence", proc_rdata, 32'hCAFEF00D);

    // Dirty conflict miss at 0x32 (idx 4, tag 1): writeback of old line first.
    tick();
    proc_addr = 30'h32;
    #1;
    check_eq("dirty_stall", proc_stall, 1);
    tick();
    check_eq("wb_mem_write", mem_write, 1);
    check_eq("wb_mem_read", mem_read, 0);
    check_eq("wb_mem_addr", mem_addr, 28'h4);
    check_eq("wb_mem_wdata", mem_wdata, 128'hCAFEF00D_DEADBEEF_11111111_00000000);
    tick();
    check_eq("wb_hold", mem_write, 1);
    mem_return('0);
    check_eq("alloc_mem_write_drop", mem_write, 0);
    check_eq("alloc_mem_read", mem_read, 1);
    check_eq("alloc_mem_addr", mem_addr, 28'hC);
    tick();
    mem_return(128'h44444444_55555555_66666666_77777777);
    check_eq("dirty_fill_stall", proc_stall, 0);
    check_eq("dirty_fill_rdata", proc_rdata, 32'h55555555);
    check_eq("dirty_fill_mem_read", mem_read, 0);

    // Clean conflict miss back to tag 0: no writeback expected.
    tick();
    proc_addr = 30'h12;
    #1;
    check_eq("clean_stall", proc_stall, 1);
    tick();
    check_eq("clean_no_write", mem_write, 0);
    check_eq("clean_mem_read", mem_read, 1);
    check_eq("clean_mem_addr", mem_addr, 28'h4);
    mem_return(128'h88888888_99999999_AAAAAAAA_BBBBBBBB);
    check_eq("clean_fill_rdata", proc_rdata, 32'h99999999);

    // Reset while allocating a different line.
    tick();
    proc_addr = 30'h20;
    tick();
    check_eq("rstmid_mem_read", mem_read, 1);
    #2 rst_n = 1'b0;
    proc_read = 1'b0;
    #1;
    check_eq("rstmid_read_drop", mem_read, 0);
    check_eq("rstmid_stall", proc_stall, 0);
    #3 rst_n = 1'b1;
    mem_return(128'h1234);
    check_eq("rstmid_resp_discard", mem_read, 0);
    proc_read = 1'b1;
    proc_addr = 30'h10;
    #1;
    check_eq("post_rst_miss_stall", proc_stall, 1);
    tick();
    check_eq("post_rst_mem_read", mem_read, 1);
    check_eq("post_rst_mem_addr", mem_addr, 28'h4);
    mem_return(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    check_eq("post_rst_rdata", proc_rdata, 32'h0A0A0A0A);
    proc_read = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
